// File: rtl/rr_arb8_if.sv
//------------------------------------------------------------------------------
// rr_arb8_if : request/grant bundle between requesters and the 8-way arbiter
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rr_arb8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] select;
    logic       valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  select,
        input  valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output select,
        output valid,
        output timeout
    );
endinterface

`default_nettype wire

// File: rtl/rr_arb8.sv
//------------------------------------------------------------------------------
// rr_arb8 : 8-way round-robin arbiter with hold limit and one dead cycle
//           between grants on the shared path
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb8 #(
    parameter int MAXHOLD = 15
) (
    input wire         clk1,
    input wire         rst,
    rr_arb8_if.slave   arb
);

    localparam logic [7:0] c_HOLD_LAST = 8'(MAXHOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_sel;
    logic [7:0] r_grant;
    logic       r_valid;
    logic       r_timeout;
    logic [7:0] r_hold;

    logic [2:0] w_pick;
    logic [2:0] w_idx;
    logic       w_held_req;
    logic       w_limit;
    logic       w_release;

    // Scan from the far end back toward r_ptr so the nearest set bit wins.
    always_comb begin
        w_pick = r_ptr;
        w_idx  = r_ptr;
        for (int i = 7; i >= 0; i--) begin
            w_idx = r_ptr + 3'(i);
            if (arb.req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    assign w_held_req = arb.req[r_sel];
    assign w_limit    = (r_hold == c_HOLD_LAST);
    assign w_release  = arb.done | ~w_held_req | w_limit;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 3'd0;
            r_sel     <= 3'd0;
            r_grant   <= 8'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_hold    <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout <= 1'b0;
                    if (|arb.req) begin
                        r_sel   <= w_pick;
                        r_grant <= 8'd1 << w_pick;
                        r_valid <= 1'b1;
                        r_hold  <= 8'd0;
                        r_state <= ST_GRANT;
                    end else begin
                        r_grant <= 8'd0;
                        r_valid <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_grant   <= 8'd0;
                        r_valid   <= 1'b0;
                        r_ptr     <= r_sel + 3'd1;
                        r_hold    <= 8'd0;
                        // A simultaneous done or dropped request counts as a normal release.
                        r_timeout <= w_limit & ~arb.done & w_held_req;
                        r_state   <= ST_GAP;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                ST_GAP: begin
                    r_timeout <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_grant   <= 8'd0;
                    r_valid   <= 1'b0;
                    r_timeout <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb.grant   = r_grant;
    assign arb.select  = r_sel;
    assign arb.valid   = r_valid;
    assign arb.timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb8.sv
//------------------------------------------------------------------------------
// tb_rr_arb8 : directed stimulus for rr_arb8 with a per-cycle reference model
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rr_arb8;

    localparam int c_MAXHOLD = 4;

    logic clk1;
    logic rst;
    int   checks;
    int   errors;

    rr_arb8_if bus ();

    rr_arb8 #(
        .MAXHOLD(c_MAXHOLD)
    ) dut (
        .clk1(clk1),
        .rst (rst),
        .arb (bus)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Reference model: who holds the path, for how long, and where the next scan starts.
    int   m_phase;   // 0 = waiting, 1 = someone holds the path, 2 = dead cycle
    int   m_ptr;
    int   m_sel;
    int   m_held;
    bit   m_valid;
    bit   m_tmo;
    bit   m_live;
    bit   m_found;

    initial begin
        m_phase = 0; m_ptr = 0; m_sel = 0; m_held = 0;
        m_valid = 0; m_tmo = 0; m_live = 0; m_found = 0;
    end

    always @(posedge clk1) begin
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_sel = 0; m_held = 0;
            m_valid = 0; m_tmo = 0; m_live = 1;
        end else if (m_phase == 0) begin
            m_tmo   = 0;
            m_found = 0;
            for (int k = 0; k < 8; k++) begin
                if (!m_found && bus.req[(m_ptr + k) % 8]) begin
                    m_sel   = (m_ptr + k) % 8;
                    m_found = 1;
                end
            end
            if (m_found) begin
                m_valid = 1;
                m_held  = 1;
                m_phase = 1;
            end else begin
                m_valid = 0;
            end
        end else if (m_phase == 1) begin
            if (bus.done || !bus.req[m_sel] || m_held >= c_MAXHOLD) begin
                m_tmo   = (m_held >= c_MAXHOLD) && !bus.done && bus.req[m_sel];
                m_valid = 0;
                m_ptr   = (m_sel + 1) % 8;
                m_phase = 2;
            end else begin
                m_held = m_held + 1;
            end
        end else begin
            m_tmo   = 0;
            m_phase = 0;
        end
    end

    always @(negedge clk1) begin
        if (m_live) begin
            logic [7:0] exp_grant;
            exp_grant = m_valid ? (8'd1 << m_sel) : 8'd0;
            checks++;
            if (bus.grant !== exp_grant || bus.valid !== m_valid ||
                bus.timeout !== m_tmo || bus.select !== 3'(m_sel)) begin
                errors++;
                $display("FAIL model t=%0t grant=%h/%h valid=%b/%b select=%0d/%0d timeout=%b/%b (got/want)",
                         $time, bus.grant, exp_grant, bus.valid, m_valid,
                         bus.select, m_sel, bus.timeout, m_tmo);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic d);
        bus.req  = r;
        bus.done = d;
        @(negedge clk1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.req  = 8'd0;
        bus.done = 1'b0;
        @(negedge clk1);
        drive(8'h00, 1'b0);
        chk("rst_valid",   32'(bus.valid),   32'd0);
        chk("rst_grant",   32'(bus.grant),   32'd0);
        chk("rst_select",  32'(bus.select),  32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);

        // Single requester, done in the third grant cycle.
        rst = 1'b0;
        drive(8'h01, 1'b0);
        chk("s1_grant",  32'(bus.grant),  32'h01);
        chk("s1_select", 32'(bus.select), 32'd0);
        chk("s1_valid",  32'(bus.valid),  32'd1);
        drive(8'h01, 1'b0);
        drive(8'h01, 1'b0);
        drive(8'h01, 1'b1);
        chk("s1_gap_valid",   32'(bus.valid),   32'd0);
        chk("s1_gap_grant",   32'(bus.grant),   32'd0);
        chk("s1_gap_timeout", 32'(bus.timeout), 32'd0);
        drive(8'h00, 1'b0);
        drive(8'h03, 1'b0);
        chk("s1_ptr1_select", 32'(bus.select), 32'd1);
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);

        // All requesting: strict rotation 0..7 then back to 0.
        rst = 1'b1;
        drive(8'h00, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(8'hFF, 1'b0);
            chk("rr_select", 32'(bus.select), 32'(k % 8));
            chk("rr_grant",  32'(bus.grant),  32'(8'd1 << (k % 8)));
            drive(8'hFF, 1'b1);
            chk("rr_gap_valid", 32'(bus.valid), 32'd0);
            drive(8'hFF, 1'b0);
        end

        // Hold limit: requester 5 holds for 4 cycles then is forced off.
        drive(8'h20, 1'b0);
        chk("to_grant1", 32'(bus.grant), 32'h20);
        for (int k = 0; k < 3; k++) begin
            drive(8'h20, 1'b0);
            chk("to_hold_grant", 32'(bus.grant), 32'h20);
            chk("to_hold_tmo",   32'(bus.timeout), 32'd0);
        end
        drive(8'h20, 1'b0);
        chk("to_pulse",       32'(bus.timeout), 32'd1);
        chk("to_pulse_valid", 32'(bus.valid),   32'd0);
        drive(8'h20, 1'b0);
        chk("to_pulse_end", 32'(bus.timeout), 32'd0);
        drive(8'h20, 1'b0);
        chk("to_regrant", 32'(bus.grant), 32'h20);
        drive(8'h00, 1'b0);
        chk("to_drop_tmo", 32'(bus.timeout), 32'd0);
        drive(8'h00, 1'b0);

        // ptr is 6: scan wraps to 0, then continues to 2.
        drive(8'h05, 1'b0);
        chk("wrap_select", 32'(bus.select), 32'd0);
        chk("wrap_grant",  32'(bus.grant),  32'h01);
        drive(8'h05, 1'b1);
        drive(8'h05, 1'b0);
        drive(8'h05, 1'b0);
        chk("wrap_next_select", 32'(bus.select), 32'd2);
        drive(8'h05, 1'b1);
        drive(8'h00, 1'b0);

        // Reset in the middle of a grant to requester 5.
        drive(8'h20, 1'b0);
        chk("mid_select", 32'(bus.select), 32'd5);
        drive(8'h20, 1'b0);
        rst = 1'b1;
        drive(8'h20, 1'b0);
        chk("mid_rst_grant",  32'(bus.grant),  32'd0);
        chk("mid_rst_valid",  32'(bus.valid),  32'd0);
        chk("mid_rst_select", 32'(bus.select), 32'd0);
        rst = 1'b0;
        drive(8'hFF, 1'b0);
        chk("mid_first_grant", 32'(bus.grant), 32'h01);
        drive(8'hFF, 1'b1);
        drive(8'h00, 1'b0);

        // done coincides with the hold limit; other req bits wiggle meanwhile.
        drive(8'h02, 1'b0);
        chk("lim_select", 32'(bus.select), 32'd1);
        drive(8'hFE, 1'b0);
        drive(8'h03, 1'b0);
        drive(8'h02, 1'b0);
        drive(8'h02, 1'b1);
        chk("lim_tmo",   32'(bus.timeout), 32'd0);
        chk("lim_valid", 32'(bus.valid),   32'd0);
        drive(8'h06, 1'b0);
        drive(8'h06, 1'b0);
        chk("lim_next_select", 32'(bus.select), 32'd2);
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 SHALL have parameter MAXHOLD, default 15: maximum number of consecutive cycles one grant may be held before a forced release (legal range 1..255).
REQ-002 SHALL have port clk1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 8 bits: request from requesters 0..7, level-sensitive.
REQ-005 SHALL have port done, input, 1 bit: the current grant holder releases the shared 8-way path.
REQ-006 SHALL have port grant, output, 8 bits: one-hot grant, equal to the 3-to-8 decode of select when valid=1, else 0.
REQ-007 SHALL have port select, output, 3 bits: index of the granted requester, for driving the shared 3-to-8 path decoder.
REQ-008 SHALL have port valid, output, 1 bit: a grant is active.
REQ-009 SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release at MAXHOLD.

Function
REQ-010 SHALL implement the states IDLE, GRANT and GAP, with all outputs registered.
REQ-011 In IDLE with req!=0, the block SHALL pick the first set req bit scanning upward from ptr (ptr, ptr+1, ..., wrapping 7->0), load that index into select, set valid=1 and enter GRANT on the same edge; latency is 1 cycle from req sampled to grant visible.
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE with valid=0, grant=0 and select holding its last value.
REQ-013 In GRANT, a hold counter SHALL start at 0 on entry and increment by 1 each cycle.
REQ-014 GRANT SHALL end on the first cycle in which done=1, req[select]=0, or the hold counter equals MAXHOLD-1; the next edge SHALL clear valid and grant and enter GAP.
REQ-015 On leaving GRANT, ptr SHALL be set to (select+1) mod 8, wrapping from 7 to 0.
REQ-016 timeout SHALL pulse for exactly 1 cycle, coincident with the GAP cycle, only when the release cause was the hold limit.
REQ-017 If done=1 or req[select]=0 occurs in the same cycle the limit is reached, the release SHALL be treated as normal and timeout SHALL stay 0.
REQ-018 GAP SHALL last exactly 1 cycle with valid=0 and grant=0, then move to IDLE, giving at least 1 dead cycle between grants on the shared path.
REQ-019 Changes on req other than req[select] during GRANT or GAP SHALL have no effect until IDLE evaluates them.
REQ-020 grant SHALL never have more than one bit set, and SHALL be 0 whenever valid=0.
REQ-021 With MAXHOLD=1, every grant SHALL last exactly 1 cycle; when done=0 and req[select]=1 this is a timeout release.
REQ-022 No requester continuously asserting req SHALL wait more than 7 grants before it is served.

Reset
REQ-023 With rst=1 at a clk1 edge, the block SHALL set state=IDLE, ptr=0, select=0, grant=0, valid=0, timeout=0 and hold counter=0.
REQ-024 rst SHALL take priority over every other input, including in the middle of GRANT or GAP; outputs SHALL be 0 after that edge, and arbitration SHALL resume from ptr=0 on the first edge with rst=0.

Verification
REQ-025 The bench SHALL cover: after reset, req=8'b0000_0001 with done pulsed in cycle 3 of the grant -> grant=8'h01 and select=0 one cycle after req; release and GAP follow; ptr=1.
REQ-026 The bench SHALL cover: req=8'hFF held and done pulsed each grant -> grants in order 0,1,2,...,7,0, each separated by a 1-cycle GAP with valid=0.
REQ-027 The bench SHALL cover: MAXHOLD=4, req=8'h20 held and done=0 -> grant=8'h20 for 4 cycles, then timeout=1 for 1 cycle, then re-grant of 8'h20 after IDLE.
REQ-028 The bench SHALL cover: ptr=6 and req=8'b0000_0101 -> select=0 (wrap), then select=2 on the next grant.
REQ-029 The bench SHALL cover: rst=1 asserted during GRANT with select=5 -> grant=0, valid=0 and select=0 next cycle; with req=8'hFF afterwards the first grant is 8'h01.
REQ-030 The bench SHALL cover: done=1 in the same cycle the hold limit is reached -> timeout stays 0 and the next ptr is select+1.
